// File: rtl/exe_stage.sv
// Y86-64 execute stage with E->M pipeline register: ALU operand select, ALU, condition codes, cmov/jXX condition.
// Optional feature macro EXE_MUL_EN: enables OPq ifun 4 (low 64 bits of valB*valA).
module exe_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  E_in_code,
    input  logic [3:0]  E_in_fun,
    input  logic [63:0] E_val_a,
    input  logic [63:0] E_val_b,
    input  logic [63:0] E_val_c,
    input  logic [3:0]  E_dst_e,
    input  logic [3:0]  E_dst_m,
    input  logic [1:0]  E_stat,
    input  logic        set_cc,
    output logic [63:0] e_val_e,
    output logic [3:0]  e_dst_e,
    output logic        e_cnd,
    output logic [3:0]  M_in_code,
    output logic [63:0] M_val_e,
    output logic [63:0] M_val_a,
    output logic [3:0]  M_dst_e,
    output logic [3:0]  M_dst_m,
    output logic [1:0]  M_stat,
    output logic        M_cnd
);
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;
`ifdef EXE_MUL_EN
    localparam logic [3:0] ALU_MUL = 4'h4;
`endif

    logic [63:0] w_alu_a;
    logic [63:0] w_alu_b;
    logic [63:0] w_result;
    logic        w_zf;
    logic        w_sf;
    logic        w_of;
    logic        w_cond;
    logic        r_zf;
    logic        r_sf;
    logic        r_of;

    always_comb begin
        w_alu_a = 64'd0;
        case (E_in_code)
            I_RRMOVQ, I_OPQ:             w_alu_a = E_val_a;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_alu_a = E_val_c;
            I_CALL, I_PUSHQ:             w_alu_a = -64'd8;
            I_RET, I_POPQ:               w_alu_a = 64'd8;
            default:                     w_alu_a = 64'd0;
        endcase
    end

    always_comb begin
        w_alu_b = 64'd0;
        case (E_in_code)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: w_alu_b = E_val_b;
            default: w_alu_b = 64'd0;
        endcase
    end

    // Only OPq selects the ALU function; address/stack arithmetic always adds.
    always_comb begin
        w_result = 64'd0;
        w_of     = 1'b0;
        if (E_in_code == I_OPQ) begin
            case (E_in_fun)
                ALU_ADD: begin
                    w_result = w_alu_b + w_alu_a;
                    w_of     = (w_alu_a[63] == w_alu_b[63]) && (w_result[63] != w_alu_a[63]);
                end
                ALU_SUB: begin
                    w_result = w_alu_b - w_alu_a;
                    w_of     = (w_alu_a[63] != w_alu_b[63]) && (w_result[63] != w_alu_b[63]);
                end
                ALU_AND: w_result = w_alu_b & w_alu_a;
                ALU_XOR: w_result = w_alu_b ^ w_alu_a;
`ifdef EXE_MUL_EN
                ALU_MUL: w_result = w_alu_b * w_alu_a;
`endif
                default: w_result = 64'd0;
            endcase
        end else begin
            w_result = w_alu_b + w_alu_a;
            w_of     = (w_alu_a[63] == w_alu_b[63]) && (w_result[63] != w_alu_a[63]);
        end
        w_zf = (w_result == 64'd0);
        w_sf = w_result[63];
    end

    // Condition uses the CC held from earlier instructions, not this cycle's flags.
    always_comb begin
        w_cond = 1'b0;
        case (E_in_fun)
            4'h0:    w_cond = 1'b1;
            4'h1:    w_cond = (r_sf ^ r_of) | r_zf;
            4'h2:    w_cond = r_sf ^ r_of;
            4'h3:    w_cond = r_zf;
            4'h4:    w_cond = ~r_zf;
            4'h5:    w_cond = ~(r_sf ^ r_of);
            4'h6:    w_cond = ~(r_sf ^ r_of) & ~r_zf;
            default: w_cond = 1'b0;
        endcase
    end

    assign e_val_e = w_result;
    assign e_cnd   = ((E_in_code == I_RRMOVQ) || (E_in_code == I_JXX)) ? w_cond : 1'b0;
    assign e_dst_e = ((E_in_code == I_RRMOVQ) && !e_cnd) ? REG_NONE : E_dst_e;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (set_cc) begin
            r_zf <= w_zf;
            r_sf <= w_sf;
            r_of <= w_of;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            M_in_code <= I_NOP;
            M_val_e   <= 64'd0;
            M_val_a   <= 64'd0;
            M_dst_e   <= REG_NONE;
            M_dst_m   <= REG_NONE;
            M_stat    <= 2'b00;
            M_cnd     <= 1'b0;
        end else begin
            M_in_code <= E_in_code;
            M_val_e   <= e_val_e;
            M_val_a   <= E_val_a;
            M_dst_e   <= e_dst_e;
            M_dst_m   <= E_dst_m;
            M_stat    <= E_stat;
            M_cnd     <= e_cnd;
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: ISA-level reference model checked every negedge, plus directed literal vectors.
module tb_exe_stage;
    logic        clock;
    logic        reset;
    logic [3:0]  E_in_code;
    logic [3:0]  E_in_fun;
    logic [63:0] E_val_a;
    logic [63:0] E_val_b;
    logic [63:0] E_val_c;
    logic [3:0]  E_dst_e;
    logic [3:0]  E_dst_m;
    logic [1:0]  E_stat;
    logic        set_cc;
    logic [63:0] e_val_e;
    logic [3:0]  e_dst_e;
    logic        e_cnd;
    logic [3:0]  M_in_code;
    logic [63:0] M_val_e;
    logic [63:0] M_val_a;
    logic [3:0]  M_dst_e;
    logic [3:0]  M_dst_m;
    logic [1:0]  M_stat;
    logic        M_cnd;

    int checks = 0;
    int errors = 0;

    exe_stage dut (
        .clock(clock), .reset(reset),
        .E_in_code(E_in_code), .E_in_fun(E_in_fun),
        .E_val_a(E_val_a), .E_val_b(E_val_b), .E_val_c(E_val_c),
        .E_dst_e(E_dst_e), .E_dst_m(E_dst_m), .E_stat(E_stat), .set_cc(set_cc),
        .e_val_e(e_val_e), .e_dst_e(e_dst_e), .e_cnd(e_cnd),
        .M_in_code(M_in_code), .M_val_e(M_val_e), .M_val_a(M_val_a),
        .M_dst_e(M_dst_e), .M_dst_m(M_dst_m), .M_stat(M_stat), .M_cnd(M_cnd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: {OF, result} from ISA semantics using 65-bit signed arithmetic.
    function automatic logic [64:0] f_alu(input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        logic [63:0] opa;
        logic [63:0] opb;
        logic [64:0] wide;
        opa = 64'd0;
        if (ic == 4'h2 || ic == 4'h6) opa = a;
        else if (ic >= 4'h3 && ic <= 4'h5) opa = c;
        else if (ic == 4'h8 || ic == 4'hA) opa = 64'hFFFF_FFFF_FFFF_FFF8;
        else if (ic == 4'h9 || ic == 4'hB) opa = 64'd8;
        opb = (ic >= 4'h4 && ic <= 4'hB && ic != 4'h7) ? b : 64'd0;
        if (ic == 4'h6 && fn == 4'h1) begin
            wide = {opb[63], opb} - {opa[63], opa};
            return {wide[64] != wide[63], wide[63:0]};
        end
        if (ic == 4'h6 && fn == 4'h2) return {1'b0, opb & opa};
        if (ic == 4'h6 && fn == 4'h3) return {1'b0, opb ^ opa};
`ifdef EXE_MUL_EN
        if (ic == 4'h6 && fn == 4'h4) return {1'b0, opb * opa};
`endif
        if (ic == 4'h6 && fn != 4'h0) return 65'd0;
        wide = {opb[63], opb} + {opa[63], opa};
        return {wide[64] != wide[63], wide[63:0]};
    endfunction

    function automatic logic f_cond(input logic [3:0] fn, input logic zf, input logic sf, input logic of);
        logic less;
        less = (sf != of);
        case (fn)
            4'h0: return 1'b1;
            4'h1: return less || zf;
            4'h2: return less;
            4'h3: return zf;
            4'h4: return !zf;
            4'h5: return !less;
            4'h6: return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    logic [64:0] mdl_alu;
    logic        mdl_cnd;
    logic [3:0]  mdl_dst;
    logic        cc_zf, cc_sf, cc_of;
    logic [3:0]  x_code, x_dst_e, x_dst_m;
    logic [63:0] x_val_e, x_val_a;
    logic [1:0]  x_stat;
    logic        x_cnd;

    always_comb begin
        mdl_alu = f_alu(E_in_code, E_in_fun, E_val_a, E_val_b, E_val_c);
        mdl_cnd = (E_in_code == 4'h2 || E_in_code == 4'h7) ? f_cond(E_in_fun, cc_zf, cc_sf, cc_of) : 1'b0;
        mdl_dst = (E_in_code == 4'h2 && !mdl_cnd) ? 4'hF : E_dst_e;
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cc_zf <= 1'b1; cc_sf <= 1'b0; cc_of <= 1'b0;
            x_code <= 4'h1; x_val_e <= 64'd0; x_val_a <= 64'd0;
            x_dst_e <= 4'hF; x_dst_m <= 4'hF; x_stat <= 2'b00; x_cnd <= 1'b0;
        end else begin
            if (set_cc) begin
                cc_zf <= (mdl_alu[63:0] == 64'd0);
                cc_sf <= mdl_alu[63];
                cc_of <= mdl_alu[64];
            end
            x_code <= E_in_code; x_val_e <= mdl_alu[63:0]; x_val_a <= E_val_a;
            x_dst_e <= mdl_dst; x_dst_m <= E_dst_m; x_stat <= E_stat; x_cnd <= mdl_cnd;
        end
    end

    always @(negedge clock) begin
        chk("e_val_e", e_val_e, mdl_alu[63:0]);
        chk("e_dst_e", 64'(e_dst_e), 64'(mdl_dst));
        chk("e_cnd", 64'(e_cnd), 64'(mdl_cnd));
        chk("M_in_code", 64'(M_in_code), 64'(x_code));
        chk("M_val_e", M_val_e, x_val_e);
        chk("M_val_a", M_val_a, x_val_a);
        chk("M_dst_e", 64'(M_dst_e), 64'(x_dst_e));
        chk("M_dst_m", 64'(M_dst_m), 64'(x_dst_m));
        chk("M_stat", 64'(M_stat), 64'(x_stat));
        chk("M_cnd", 64'(M_cnd), 64'(x_cnd));
    end

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c, input logic [3:0] de, input logic scc);
        E_in_code = ic; E_in_fun = fn; E_val_a = a; E_val_b = b; E_val_c = c;
        E_dst_e = de; E_dst_m = 4'h6; E_stat = 2'b00; set_cc = scc;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0);
        #2;
        chk("rst M_in_code", 64'(M_in_code), 64'h1);
        chk("rst M_dst_e", 64'(M_dst_e), 64'hF);
        chk("rst M_dst_m", 64'(M_dst_m), 64'hF);
        chk("rst M_val_e", M_val_e, 64'd0);
        chk("rst M_stat", 64'(M_stat), 64'd0);
        chk("rst je ZF=1", 64'(e_cnd), 64'd1);
        step();
        reset = 1'b0;

        drive(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h2, 1'b1); #1;
        chk("add 5+7", e_val_e, 64'd12);
        step();
        chk("M_val_e add", M_val_e, 64'd12);
        drive(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0); #1;
        chk("je after 12", 64'(e_cnd), 64'd0);
        step();
        drive(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0); #1;
        chk("jg after 12", 64'(e_cnd), 64'd1);
        step();

        drive(4'h6, 4'h1, 64'd7, 64'd7, 64'd0, 4'h2, 1'b1); #1;
        chk("sub 7-7", e_val_e, 64'd0);
        step();
        drive(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0); #1;
        chk("je after 0", 64'(e_cnd), 64'd1);
        step();
        drive(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0); #1;
        chk("jne after 0", 64'(e_cnd), 64'd0);
        step();

        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 1'b1); #1;
        chk("add ovf", e_val_e, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        drive(4'h2, 4'h2, 64'h11, 64'd0, 64'd0, 4'h3, 1'b0); #1;
        chk("cmovl SF=OF=1", 64'(e_cnd), 64'd0);
        chk("cmovl dst", 64'(e_dst_e), 64'hF);
        step();
        drive(4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0); #1;
        chk("jge SF=OF=1", 64'(e_cnd), 64'd1);
        step();

        drive(4'h2, 4'h1, 64'h22, 64'd0, 64'd0, 4'h3, 1'b0); #1;
        chk("cmovle false dst", 64'(e_dst_e), 64'hF);
        step();
        chk("cmovle M_dst_e", 64'(M_dst_e), 64'hF);
        drive(4'h2, 4'h0, 64'h55, 64'd0, 64'd0, 4'h3, 1'b0); #1;
        chk("rrmovq dst", 64'(e_dst_e), 64'h3);
        chk("rrmovq val", e_val_e, 64'h55);
        step();

        drive(4'hA, 4'h0, 64'h9, 64'h100, 64'd0, 4'h4, 1'b0); #1;
        chk("push", e_val_e, 64'hF8);
        step();
        drive(4'hB, 4'h0, 64'h9, 64'h100, 64'd0, 4'h4, 1'b0); #1;
        chk("pop", e_val_e, 64'h108);
        step();
        drive(4'h3, 4'h0, 64'd0, 64'h999, 64'h2A, 4'h1, 1'b0); #1;
        chk("irmovq", e_val_e, 64'h2A);
        step();
        drive(4'h5, 4'h0, 64'd0, 64'h1000, 64'h18, 4'hF, 1'b0); #1;
        chk("mrmovq addr", e_val_e, 64'h1018);
        step();
        drive(4'h8, 4'h0, 64'd0, 64'd0, 64'h400, 4'h4, 1'b0); #1;
        chk("call wrap", e_val_e, 64'hFFFF_FFFF_FFFF_FFF8);
        step();
        drive(4'h6, 4'h2, 64'hF0F0, 64'hFF00, 64'd0, 4'h2, 1'b0); #1;
        chk("andq", e_val_e, 64'hF000);
        step();
        drive(4'h6, 4'h3, 64'hF0F0, 64'hFF00, 64'd0, 4'h2, 1'b0); #1;
        chk("xorq", e_val_e, 64'h0FF0);
        step();
        drive(4'h6, 4'h4, 64'd6, 64'd7, 64'd0, 4'h2, 1'b0); #1;
`ifdef EXE_MUL_EN
        chk("mulq", e_val_e, 64'd42);
`else
        chk("ifun4 off", e_val_e, 64'd0);
`endif
        step();
        drive(4'h6, 4'h9, 64'd6, 64'd7, 64'd0, 4'h2, 1'b0); #1;
        chk("bad ifun", e_val_e, 64'd0);
        step();
        drive(4'h1, 4'h0, 64'hAB, 64'd0, 64'd0, 4'hF, 1'b0);
        E_stat = 2'b01;
        step();
        chk("M_stat hlt", 64'(M_stat), 64'h1);
        chk("M_val_a", M_val_a, 64'hAB);

        drive(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h2, 1'b1);
        step();
        drive(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0);
        E_stat = 2'b10;
        #1;
        chk("je before rst", 64'(e_cnd), 64'd0);
        step();
        #1;
        reset = 1'b1;
        #1;
        chk("midrst M_in_code", 64'(M_in_code), 64'h1);
        chk("midrst M_dst_e", 64'(M_dst_e), 64'hF);
        chk("midrst M_stat", 64'(M_stat), 64'h0);
        chk("midrst je ZF=1", 64'(e_cnd), 64'd1);
        step();
        reset = 1'b0;
        drive(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h2, 1'b0);
        step();
        chk("first load after rst", M_val_e, 64'd12);
        drive(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0); #1;
        chk("set_cc=0 holds ZF", 64'(e_cnd), 64'd1);
        step();

        for (int i = 0; i < 40; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            E_stat = 2'($urandom_range(0, 3));
            step();
        end

        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
